// File: rtl/apb_master_arbiter.sv
// Round-robin APB master: two local requesters share one APB bus, with one-hot PSEL from the address MSB.
// Optional PREADY watchdog with per-requester ERR outputs when APB_TIMEOUT_EN is defined.
//
// state  | meaning
// IDLE   | bus free; arbitrate, handshake and latch the winner's payload
// SETUP  | PSEL asserted, PENABLE low, one cycle only
// ACCESS | PENABLE high; wait for PREADY (or the watchdog), then release the bus
module apb_master_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int SLAVE_NUM      = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  REQ0_VALID,
    input  logic                  REQ0_WRITE,
    input  logic [ADDR_WIDTH-1:0] REQ0_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ0_WDATA,
    output logic                  REQ0_READY,
    output logic                  REQ0_DONE,
    output logic [DATA_WIDTH-1:0] REQ0_RDATA,
    input  logic                  REQ1_VALID,
    input  logic                  REQ1_WRITE,
    input  logic [ADDR_WIDTH-1:0] REQ1_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ1_WDATA,
    output logic                  REQ1_READY,
    output logic                  REQ1_DONE,
    output logic [DATA_WIDTH-1:0] REQ1_RDATA,
`ifdef APB_TIMEOUT_EN
    output logic                  REQ0_ERR,
    output logic                  REQ1_ERR,
`endif
    output logic [SLAVE_NUM-1:0]  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

    localparam logic [SLAVE_NUM-1:0] PSEL_S0 = SLAVE_NUM'(1);
    localparam logic [SLAVE_NUM-1:0] PSEL_S1 = SLAVE_NUM'(2);

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  gnt_idx_q, gnt_idx_d;
    logic [SLAVE_NUM-1:0]  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  done0_q, done0_d, done1_q, done1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                  grant0, grant1;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  timeout_hit;
    logic                  xfer_end;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             err0_q, err0_d, err1_q, err1_d;

    assign timeout_hit = (wait_cnt_q == '0) & ~PREADY;
    assign REQ0_ERR    = err0_q;
    assign REQ1_ERR    = err1_q;
`else
    assign timeout_hit = 1'b0;
`endif

    // last_grant_q=1 means REQ1 won last, so REQ0 has priority on a tie
    assign grant0   = REQ0_VALID & (~REQ1_VALID | last_grant_q);
    assign grant1   = REQ1_VALID & (~REQ0_VALID | ~last_grant_q);
    assign sel_addr = grant1 ? REQ1_ADDR : REQ0_ADDR;
    assign xfer_end = (state_q == ST_ACCESS) & (PREADY | timeout_hit);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (grant0 | grant1) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (xfer_end) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        REQ0_READY = (state_q == ST_IDLE) & grant0;
        REQ1_READY = (state_q == ST_IDLE) & grant1;
        REQ0_DONE  = done0_q;
        REQ1_DONE  = done1_q;
        REQ0_RDATA = rdata0_q;
        REQ1_RDATA = rdata1_q;
        PSEL       = psel_q;
        PENABLE    = penable_q;
        PWRITE     = pwrite_q;
        PADDR      = paddr_q;
        PWDATA     = pwdata_q;
    end

    always_comb begin
        last_grant_d = last_grant_q;
        gnt_idx_d    = gnt_idx_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
`ifdef APB_TIMEOUT_EN
        wait_cnt_d   = wait_cnt_q;
        err0_d       = 1'b0;
        err1_d       = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant0 | grant1) begin
                    gnt_idx_d    = grant1;
                    last_grant_d = grant1;
                    pwrite_d     = grant1 ? REQ1_WRITE : REQ0_WRITE;
                    paddr_d      = sel_addr;
                    pwdata_d     = grant1 ? REQ1_WDATA : REQ0_WDATA;
                    psel_d       = sel_addr[ADDR_WIDTH-1] ? PSEL_S1 : PSEL_S0;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
                wait_cnt_d = CNT_W'(TIMEOUT_CYCLES - 1);
`endif
            end
            ST_ACCESS: begin
                if (xfer_end) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    done0_d   = ~gnt_idx_q;
                    done1_d   = gnt_idx_q;
                    if (PREADY & ~pwrite_q) begin
                        if (gnt_idx_q) rdata1_d = PRDATA;
                        else           rdata0_d = PRDATA;
                    end
`ifdef APB_TIMEOUT_EN
                    err0_d = timeout_hit & ~gnt_idx_q;
                    err1_d = timeout_hit & gnt_idx_q;
`endif
                end
`ifdef APB_TIMEOUT_EN
                else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            last_grant_q <= 1'b1;
            gnt_idx_q    <= 1'b0;
            psel_q       <= '0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
`ifdef APB_TIMEOUT_EN
            wait_cnt_q   <= '0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
`endif
        end else begin
            last_grant_q <= last_grant_d;
            gnt_idx_q    <= gnt_idx_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
`ifdef APB_TIMEOUT_EN
            wait_cnt_q   <= wait_cnt_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
`endif
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: single read, waited write, contention, reset abort, idle.
// The watchdog scenario is included when APB_TIMEOUT_EN is defined.
module tb_apb_master_arbiter;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        REQ0_VALID, REQ0_WRITE, REQ0_READY, REQ0_DONE;
    logic [31:0] REQ0_ADDR, REQ0_WDATA, REQ0_RDATA;
    logic        REQ1_VALID, REQ1_WRITE, REQ1_READY, REQ1_DONE;
    logic [31:0] REQ1_ADDR, REQ1_WDATA, REQ1_RDATA;
    logic [1:0]  PSEL;
    logic        PENABLE, PWRITE, PREADY;
    logic [31:0] PADDR, PWDATA, PRDATA;
`ifdef APB_TIMEOUT_EN
    logic        REQ0_ERR, REQ1_ERR;
`endif

    int checks = 0;
    int errors = 0;

    always #5 PCLK = ~PCLK;

    apb_master_arbiter dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .REQ0_VALID(REQ0_VALID), .REQ0_WRITE(REQ0_WRITE), .REQ0_ADDR(REQ0_ADDR),
        .REQ0_WDATA(REQ0_WDATA), .REQ0_READY(REQ0_READY), .REQ0_DONE(REQ0_DONE),
        .REQ0_RDATA(REQ0_RDATA),
        .REQ1_VALID(REQ1_VALID), .REQ1_WRITE(REQ1_WRITE), .REQ1_ADDR(REQ1_ADDR),
        .REQ1_WDATA(REQ1_WDATA), .REQ1_READY(REQ1_READY), .REQ1_DONE(REQ1_DONE),
        .REQ1_RDATA(REQ1_RDATA),
`ifdef APB_TIMEOUT_EN
        .REQ0_ERR(REQ0_ERR), .REQ1_ERR(REQ1_ERR),
`endif
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        PRESETn = 1'b0;
        REQ0_VALID = 0; REQ0_WRITE = 0; REQ0_ADDR = '0; REQ0_WDATA = '0;
        REQ1_VALID = 0; REQ1_WRITE = 0; REQ1_ADDR = '0; REQ1_WDATA = '0;
        PRDATA = '0; PREADY = 0;

        // reset state
        repeat (3) @(negedge PCLK);
        #1;
        chk("rst_psel", PSEL, 2'b00);
        chk("rst_penable", PENABLE, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_done", {REQ0_DONE, REQ1_DONE}, 2'b00);
        chk("rst_rdata", {REQ0_RDATA, REQ1_RDATA}, 64'h0);
        chk("rst_ready", {REQ0_READY, REQ1_READY}, 2'b00);
        PRESETn = 1'b1;

        // single read from slave 0, zero wait states
        @(negedge PCLK);
        REQ0_VALID = 1; REQ0_WRITE = 0; REQ0_ADDR = 32'h0000_0010;
        PREADY = 1; PRDATA = 32'hDEAD_BEEF;
        #1;
        chk("rd_ready0", REQ0_READY, 1);
        chk("rd_ready1", REQ1_READY, 0);
        @(negedge PCLK);
        REQ0_VALID = 0;
        #1;
        chk("rd_setup_psel", PSEL, 2'b01);
        chk("rd_setup_penable", PENABLE, 0);
        chk("rd_setup_paddr", PADDR, 32'h0000_0010);
        chk("rd_setup_pwrite", PWRITE, 0);
        chk("rd_setup_ready0", REQ0_READY, 0);
        @(negedge PCLK);
        #1;
        chk("rd_access_psel", PSEL, 2'b01);
        chk("rd_access_penable", PENABLE, 1);
        chk("rd_access_done0", REQ0_DONE, 0);
        @(negedge PCLK);
        #1;
        chk("rd_end_psel", PSEL, 2'b00);
        chk("rd_end_penable", PENABLE, 0);
        chk("rd_done0", REQ0_DONE, 1);
        chk("rd_done1", REQ1_DONE, 0);
        chk("rd_rdata0", REQ0_RDATA, 32'hDEAD_BEEF);
`ifdef APB_TIMEOUT_EN
        chk("rd_err0", REQ0_ERR, 0);
`endif
        @(negedge PCLK);
        #1;
        chk("rd_done0_pulse", REQ0_DONE, 0);

        // write to slave 1 with two wait states
        REQ1_VALID = 1; REQ1_WRITE = 1; REQ1_ADDR = 32'h8000_0004; REQ1_WDATA = 32'h1234_5678;
        PREADY = 0; PRDATA = 32'hBAD0_BAD0;
        #1;
        chk("wr_ready1", REQ1_READY, 1);
        chk("wr_ready0", REQ0_READY, 0);
        @(negedge PCLK);
        REQ1_VALID = 0;
        #1;
        chk("wr_setup_psel", PSEL, 2'b10);
        chk("wr_setup_pwrite", PWRITE, 1);
        chk("wr_setup_paddr", PADDR, 32'h8000_0004);
        chk("wr_setup_pwdata", PWDATA, 32'h1234_5678);
        chk("wr_setup_penable", PENABLE, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            if (i == 2) PREADY = 1;
            #1;
            chk("wr_access_penable", PENABLE, 1);
            chk("wr_access_psel", PSEL, 2'b10);
            chk("wr_access_done1", REQ1_DONE, 0);
        end
        @(negedge PCLK);
        #1;
        chk("wr_done1", REQ1_DONE, 1);
        chk("wr_done0", REQ0_DONE, 0);
        chk("wr_end_psel", PSEL, 2'b00);
        chk("wr_rdata1_kept", REQ1_RDATA, 32'h0);
        chk("wr_rdata0_kept", REQ0_RDATA, 32'hDEAD_BEEF);

        // contention: both valid continuously, grants alternate starting with REQ0
        REQ0_VALID = 1; REQ0_WRITE = 0; REQ0_ADDR = 32'h0000_0020;
        REQ1_VALID = 1; REQ1_WRITE = 0; REQ1_ADDR = 32'h8000_0030;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("ct_ready0", REQ0_READY, (i % 2) == 0);
            chk("ct_ready1", REQ1_READY, (i % 2) == 1);
            PRDATA = 32'hA000_0000 + i;
            @(negedge PCLK);
            #1;
            chk("ct_setup_ready", {REQ0_READY, REQ1_READY}, 2'b00);
            chk("ct_setup_psel", PSEL, ((i % 2) == 0) ? 2'b01 : 2'b10);
            @(negedge PCLK);
            #1;
            chk("ct_access_penable", PENABLE, 1);
            @(negedge PCLK);
            if (i == 3) begin
                REQ0_VALID = 0; REQ1_VALID = 0;
            end
            #1;
            chk("ct_done", {REQ0_DONE, REQ1_DONE}, ((i % 2) == 0) ? 2'b10 : 2'b01);
        end
        chk("ct_rdata0", REQ0_RDATA, 32'hA000_0002);
        chk("ct_rdata1", REQ1_RDATA, 32'hA000_0003);

        // reset during ACCESS after a REQ0 grant
        @(negedge PCLK);
        REQ0_VALID = 1; REQ0_WRITE = 1; REQ0_ADDR = 32'h8000_0040; REQ0_WDATA = 32'h5555_AAAA;
        PREADY = 0;
        #1;
        chk("ra_ready0", REQ0_READY, 1);
        @(negedge PCLK);
        REQ0_VALID = 0;
        #1;
        chk("ra_setup_psel", PSEL, 2'b10);
        @(negedge PCLK);
        #1;
        chk("ra_access_penable", PENABLE, 1);
        #1;
        PRESETn = 1'b0;
        #1;
        chk("ra_psel_async", PSEL, 2'b00);
        chk("ra_penable_async", PENABLE, 0);
        chk("ra_rdata1_async", REQ1_RDATA, 32'h0);
        @(negedge PCLK);
        #1;
        chk("ra_no_done", {REQ0_DONE, REQ1_DONE}, 2'b00);
        PRESETn = 1'b1;
        REQ0_VALID = 1; REQ0_WRITE = 0; REQ0_ADDR = 32'h0000_0000;
        REQ1_VALID = 1; REQ1_WRITE = 0; REQ1_ADDR = 32'h8000_0000;
        #1;
        chk("ra_first_grant", {REQ0_READY, REQ1_READY}, 2'b10);
        REQ0_VALID = 0; REQ1_VALID = 0;
        @(negedge PCLK);
        #1;
        chk("ra_withdrawn_psel", PSEL, 2'b00);

        // idle: nothing requested for 20 cycles
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK);
            #1;
            chk("idle_quiet", {PSEL, PENABLE, REQ0_READY, REQ1_READY, REQ0_DONE, REQ1_DONE}, 7'd0);
        end

`ifdef APB_TIMEOUT_EN
        // watchdog: PREADY never rises
        @(negedge PCLK);
        REQ0_VALID = 1; REQ0_WRITE = 0; REQ0_ADDR = 32'h0000_0004; PREADY = 0;
        #1;
        chk("to_ready0", REQ0_READY, 1);
        @(negedge PCLK);
        REQ0_VALID = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge PCLK);
            #1;
            chk("to_access_penable", PENABLE, 1);
            chk("to_access_flags", {REQ0_DONE, REQ0_ERR}, 2'b00);
        end
        @(negedge PCLK);
        #1;
        chk("to_done_err", {REQ0_DONE, REQ0_ERR, REQ1_DONE, REQ1_ERR}, 4'b1100);
        chk("to_psel", {PSEL, PENABLE}, 3'b000);
        chk("to_rdata0_kept", REQ0_RDATA, 32'h0);
        @(negedge PCLK);
        #1;
        chk("to_pulse_end", {REQ0_DONE, REQ0_ERR}, 2'b00);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
